// File: rtl/ohseq_pkg.sv
// Shared defaults, phase index type and one-hot decode for the phase sequencer.
// Pure definitions: no latency, no flow control.
package ohseq_pkg;

  localparam int DEF_NUM_PHASES = 4;
  localparam int DEF_DWELL_W    = 4;
  localparam int MAX_PHASES     = 16;

  typedef logic [$clog2(MAX_PHASES)-1:0] phase_idx_t;

  // oh is LSB-aligned with P0 at bit n-1, so bit i decodes to phase n-1-i.
  function automatic phase_idx_t oh_to_idx(input logic [MAX_PHASES-1:0] oh, input int n);
    phase_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      if (oh[i] && (i < n)) idx = phase_idx_t'(n - 1 - i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_phase_seq_if.sv
// Control/status bundle of the phase sequencer; master drives requests, slave is the sequencer.
// Plain wires, no latency; there is no backpressure on this bundle.
interface onehot_phase_seq_if
  import ohseq_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int DWELL_W    = DEF_DWELL_W
);

  logic                          start;
  logic                          stop;
  logic                          mode_cont;
  logic [DWELL_W-1:0]            dwell;
  logic [NUM_PHASES-1:0]         SGlobal;
  logic [$clog2(NUM_PHASES)-1:0] phase_idx;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    output start, stop, mode_cont, dwell,
    input  SGlobal, phase_idx, busy, done, err
  );

  modport slave (
    input  start, stop, mode_cont, dwell,
    output SGlobal, phase_idx, busy, done, err
  );

endinterface

// File: rtl/ohseq_dwell_cnt.sv
// Per-phase dwell down-counter: load, decrement to zero, expire when zero.
// Load value visible the cycle after load; never stalls.
module ohseq_dwell_cnt
  import ohseq_pkg::*;
#(
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clr,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)      cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/onehot_phase_seq.sv
// One-hot phase sequencer P0(idle)..P(N-1), each active phase held dwell+1 cycles; stop aborts next edge.
// Optional sticky one-hot checker on err enabled by macro OHSEQ_ONEHOT_CHECK_EN (err tied 0 otherwise).
module onehot_phase_seq
  import ohseq_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int DWELL_W    = DEF_DWELL_W
) (
  input  logic                clk,
  input  logic                reset,
  onehot_phase_seq_if.slave   io
);

  localparam int IDX_W = $clog2(NUM_PHASES);
  localparam logic [NUM_PHASES-1:0] P0    = {1'b1, {(NUM_PHASES-1){1'b0}}};
  localparam logic [NUM_PHASES-1:0] P1    = P0 >> 1;
  localparam logic [NUM_PHASES-1:0] PLAST = NUM_PHASES'(1);

  logic [NUM_PHASES-1:0] state;
  logic [NUM_PHASES-1:0] state_nxt;
  logic [MAX_PHASES-1:0] state_ext;
  logic [DWELL_W-1:0]    dwell_q;
  logic                  cont_q;
  logic                  done_q;
  logic                  legal;
  logic                  take_start;
  logic                  abort;
  logic                  expire;
  logic                  advance;

  assign legal      = $onehot(state);
  assign take_start = legal && (state == P0) && io.start && !io.stop;
  assign abort      = legal && (state != P0) && io.stop;
  assign advance    = legal && (state != P0) && !io.stop && expire;

  // Phase k+1 sits one bit below phase k, so stepping is a right shift.
  always_comb begin
    state_nxt = state;
    if (!legal)          state_nxt = P0;
    else if (take_start) state_nxt = P1;
    else if (abort)      state_nxt = P0;
    else if (advance)    state_nxt = (state == PLAST) ? (cont_q ? P1 : P0) : (state >> 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= P0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= advance && (state == PLAST);
      if (take_start) begin
        dwell_q <= io.dwell;
        cont_q  <= io.mode_cont;
      end
    end
  end

  ohseq_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (take_start || advance),
    .clr      (abort),
    .load_val (take_start ? io.dwell : dwell_q),
    .expire   (expire)
  );

`ifdef OHSEQ_ONEHOT_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (!legal) err_q <= 1'b1;
  end

  assign io.err = err_q;
`else
  assign io.err = 1'b0;
`endif

  always_comb begin
    state_ext                   = '0;
    state_ext[NUM_PHASES-1:0]   = state;
  end

  assign io.SGlobal   = state;
  assign io.busy      = (state != P0);
  assign io.done      = done_q;
  assign io.phase_idx = IDX_W'(oh_to_idx(state_ext, NUM_PHASES));

endmodule

// File: tb/tb_onehot_phase_seq.sv
// Scoreboard bench for onehot_phase_seq (NUM_PHASES=4, DWELL_W=4): stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_onehot_phase_seq;

  typedef struct {
    int         cyc;
    logic [3:0] sg;
    logic       dn;
    logic       er;
    string      tag;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_pass;
  logic err_exp;
  exp_t sb[$];

  onehot_phase_seq_if #(.NUM_PHASES(4), .DWELL_W(4)) bus ();

  onehot_phase_seq #(.NUM_PHASES(4), .DWELL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] idx_of(input logic [3:0] sg);
    case (sg)
      4'b0100: return 2'd1;
      4'b0010: return 2'd2;
      4'b0001: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Monitor: every expectation is due in exactly one cycle; a late one is a failure too.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (e.cyc == cyc && bus.SGlobal == e.sg && bus.done == e.dn && bus.err == e.er &&
          bus.phase_idx == idx_of(e.sg) && bus.busy == (e.sg != 4'b1000)) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc=%0d got sg=%b idx=%0d busy=%b done=%b err=%b, expected sg=%b idx=%0d busy=%b done=%b err=%b (due cyc %0d)",
                 e.tag, cyc, bus.SGlobal, bus.phase_idx, bus.busy, bus.done, bus.err,
                 e.sg, idx_of(e.sg), (e.sg != 4'b1000), e.dn, e.er, e.cyc);
      end
    end
  end

  // Queue the expected outputs after the coming edge, then move to just past that edge.
  task automatic step(input logic [3:0] sg, input logic dn, input string tag);
    exp_t e;
    e.cyc = cyc + 1;
    e.sg  = sg;
    e.dn  = dn;
    e.er  = err_exp;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] sg, input int n, input string tag);
    for (int i = 0; i < n; i++) step(sg, 1'b0, tag);
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    err_exp       = 1'b0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode_cont = 1'b0;
    bus.dwell     = 4'd0;
    @(posedge clk);
    #1;
    step(4'b1000, 1'b0, "reset_state");
    reset = 1'b0;
    step(4'b1000, 1'b0, "idle_after_reset");

    // Single pass, dwell 0
    bus.start = 1'b1;
    step(4'b0100, 1'b0, "d0_p1");
    bus.start = 1'b0;
    step(4'b0010, 1'b0, "d0_p2");
    step(4'b0001, 1'b0, "d0_p3");
    step(4'b1000, 1'b1, "d0_done");
    step(4'b1000, 1'b0, "d0_done_once");

    // Dwell 2: three cycles per phase; later dwell changes must not matter
    bus.start = 1'b1;
    bus.dwell = 4'd2;
    step(4'b0100, 1'b0, "d2_p1");
    bus.start = 1'b0;
    bus.dwell = 4'd0;
    hold(4'b0100, 2, "d2_p1_hold");
    hold(4'b0010, 3, "d2_p2");
    hold(4'b0001, 3, "d2_p3");
    step(4'b1000, 1'b1, "d2_done");
    step(4'b1000, 1'b0, "d2_idle");

    // Continuous mode, then stop in P2
    bus.start     = 1'b1;
    bus.mode_cont = 1'b1;
    step(4'b0100, 1'b0, "cont_p1");
    bus.start     = 1'b0;
    bus.mode_cont = 1'b0;
    step(4'b0010, 1'b0, "cont_p2");
    step(4'b0001, 1'b0, "cont_p3");
    step(4'b0100, 1'b1, "cont_wrap1");
    step(4'b0010, 1'b0, "cont_p2b");
    step(4'b0001, 1'b0, "cont_p3b");
    step(4'b0100, 1'b1, "cont_wrap2");
    step(4'b0010, 1'b0, "cont_p2c");
    bus.stop = 1'b1;
    step(4'b1000, 1'b0, "cont_stop");
    bus.stop = 1'b0;
    step(4'b1000, 1'b0, "cont_stop_nodone");

    // start and stop together in idle
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step(4'b1000, 1'b0, "start_stop_idle");
    bus.stop  = 1'b0;
    bus.dwell = 4'd1;
    step(4'b0100, 1'b0, "d1_p1");
    bus.start = 1'b0;
    bus.dwell = 4'd5;
    step(4'b0100, 1'b0, "d1_p1_hold");
    hold(4'b0010, 2, "d1_p2");
    hold(4'b0001, 2, "d1_p3");
    step(4'b1000, 1'b1, "d1_done");

    // Max dwell: 16 cycles per phase, then stop mid-P2 has priority
    bus.start = 1'b1;
    bus.dwell = 4'd15;
    step(4'b0100, 1'b0, "d15_p1");
    bus.start = 1'b0;
    hold(4'b0100, 15, "d15_p1_hold");
    step(4'b0010, 1'b0, "d15_p2");
    bus.stop = 1'b1;
    step(4'b1000, 1'b0, "d15_stop");
    bus.stop = 1'b0;

    // Reset in P2 with dwell 3, then a restart with dwell 1
    bus.start = 1'b1;
    bus.dwell = 4'd3;
    step(4'b0100, 1'b0, "d3_p1");
    bus.start = 1'b0;
    hold(4'b0100, 3, "d3_p1_hold");
    step(4'b0010, 1'b0, "d3_p2");
    reset     = 1'b1;
    bus.start = 1'b1;
    step(4'b1000, 1'b0, "reset_mid_run");
    reset     = 1'b0;
    bus.dwell = 4'd1;
    step(4'b0100, 1'b0, "post_rst_p1");
    bus.start = 1'b0;
    step(4'b0100, 1'b0, "post_rst_p1_hold");
    hold(4'b0010, 2, "post_rst_p2");
    hold(4'b0001, 2, "post_rst_p3");
    step(4'b1000, 1'b1, "post_rst_done");

    // Illegal state 0110 recovers to idle; err is sticky only with the checker built in
    @(negedge clk);
    #1;
    force dut.state = 4'b0110;
    #2;
    release dut.state;
`ifdef OHSEQ_ONEHOT_CHECK_EN
    err_exp = 1'b1;
`endif
    step(4'b1000, 1'b0, "illegal_recover");
    step(4'b1000, 1'b0, "err_sticky");
    reset   = 1'b1;
    err_exp = 1'b0;
    step(4'b1000, 1'b0, "err_cleared");
    reset = 1'b0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain pending=%0d expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/onehot_phase_seq.md
ONEHOT_PHASE_SEQ -- requirements
Module: onehot_phase_seq

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4, meaning the number of one-hot phases including idle phase P0; legal range 2..16.
REQ-002 SHALL have parameter DWELL_W, default 4, meaning the width of the per-phase dwell count.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  the reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a sequence; sampled only in P0.
REQ-006 SHALL have port stop  input  1  abort request; returns to P0 at the next edge.
REQ-007 SHALL have port mode_cont  input  1  continuous-loop mode select; sampled with start.
REQ-008 SHALL have port dwell  input  DWELL_W  extra cycles per active phase; sampled with start.
REQ-009 SHALL have port SGlobal  output  NUM_PHASES  one-hot phase vector; P0 is the MSB and Pk is bit NUM_PHASES-1-k.
REQ-010 SHALL have port phase_idx  output  $clog2(NUM_PHASES)  binary index k of the current phase.
REQ-011 SHALL have port busy  output  1  high whenever the phase is not P0.
REQ-012 SHALL have port done  output  1  one-cycle pulse on sequence completion.
REQ-013 SHALL have port err  output  1  sticky one-hot violation flag.

Function
REQ-014 SHALL be a registered state machine with phases P0 (idle) through P(NUM_PHASES-1); all outputs are registered or decoded only from registers.
REQ-015 SHALL, in P0 with start=1 and stop=0, latch dwell into dwell_q and mode_cont into cont_q, then enter P1 at the next edge.
REQ-016 SHALL hold each active phase P1..P(NUM_PHASES-1) for exactly dwell_q+1 cycles; dwell_q=0 gives one cycle per phase, and dwell=2^DWELL_W-1 gives 2^DWELL_W cycles.
REQ-017 SHALL, when the dwell of P(NUM_PHASES-1) expires, go to P0 when cont_q=0 and to P1 when cont_q=1.
REQ-018 SHALL assert done for exactly one cycle, the first cycle after leaving P(NUM_PHASES-1), in both modes.
REQ-019 SHALL, on stop=1 in any active phase, enter P0 at the next edge with no done pulse; stop has priority over start and over dwell expiry.
REQ-020 SHALL ignore start while busy, and SHALL ignore changes to dwell and mode_cont after they are latched.
REQ-021 SHALL map any non-one-hot state register value to P0 at the next edge.
REQ-022 SHALL, when NUM_PHASES=2, alternate between P0 and P1 only.

Reset
REQ-023 SHALL, on reset=1 at a clk edge (including mid-sequence), set SGlobal to P0 (MSB only), phase_idx=0, busy=0, done=0, err=0, dwell counter=0, dwell_q=0 and cont_q=0; reset overrides start and stop.

Configuration
REQ-024 SHALL, with macro OHSEQ_ONEHOT_CHECK_EN defined, set err when the state register is not exactly one-hot; err stays high until reset, and REQ-021 recovery still applies.
REQ-025 SHALL, without OHSEQ_ONEHOT_CHECK_EN, keep the err port present and tie it to 0.

Structure
REQ-026 SHALL place default parameter constants, the phase index type, and the one-hot-to-index function in package ohseq_pkg.
REQ-027 SHALL implement the dwell down-counter (load, decrement, expire flag) as sub-module ohseq_dwell_cnt.

Verification
REQ-028 SHALL cover: NUM_PHASES=4, dwell=0, start for 1 cycle -> SGlobal 1000,0100,0010,0001,1000 on consecutive cycles; done=1 in the last 1000 cycle only.
REQ-029 SHALL cover: dwell=2, mode_cont=0 -> each of 0100/0010/0001 held 3 cycles, busy high for 9 cycles, one done pulse.
REQ-030 SHALL cover: mode_cont=1, dwell=0 -> 0100,0010,0001,0100,...; done pulses every 3 cycles; stop during 0010 -> 1000 next cycle with no done.
REQ-031 SHALL cover: start and stop both high in P0 -> stays 1000 with busy=0; dwell changed from 1 to 5 mid-run -> phases still last 2 cycles.
REQ-032 SHALL cover: reset asserted during 0010 with dwell=3 -> next edge gives SGlobal=1000, done=0, phase_idx=0; a following start runs with the new dwell.
REQ-033 SHALL cover: with OHSEQ_ONEHOT_CHECK_EN, force state to 0110 -> next cycle SGlobal=1000 and err=1 until reset; without the macro -> err stays 0.
